rom_page_scanner: RTL and testbench
===================================

// Module: rom_page_scanner
// PURPOSE
//  Paged ROM-image entry/viewer engine for the i4001 programmer top level, in one CLK domain.
//  Input mode: writes switch words into ROM storage column by column and mirrors them to the DMD.
//  View mode: continuously scans the selected page from ROM into the DMD column buffer.
//  Exports the current page number for the 7-seg driver.
// PARAMETERS
//  DATA_W     16  width of one column word (ROM data and DMD column)
//  COLS       32  columns per page; power of two; COL_W = $clog2(COLS)
//  PAGES      64  page count; power of two; PAGE_W = $clog2(PAGES); ADDR_W = PAGE_W+COL_W
//  SCAN_DIV   4   CLK cycles per scan tick in view mode (>=1)
//  ROM_LAT    1   cycles from rom_re to rom_rdata valid (>=1)
//  AUTO_SCANS 8   full-page scans before auto page advance (AUTO_PAGE_EN only)
// PORTS
//  CLK         in   1       system clock
//  RESET       in   1       asynchronous, active-high reset
//  mode        in   2       0=input, 1=run, 2=debug, 3=reserved (treated as run)
//  step        in   1       raw async level; rising edge = commit one input word
//  page_up     in   1       raw async level; rising edge = next page (view modes)
//  page_dn     in   1       raw async level; rising edge = previous page (view modes)
//  din         in   DATA_W  switch word to commit
//  rom_addr    out  ADDR_W  {page, col}
//  rom_we      out  1       1-cycle write strobe; rom_wdata valid same cycle
//  rom_wdata   out  DATA_W  write data
//  rom_re      out  1       1-cycle read strobe
//  rom_rdata   in   DATA_W  read data, valid ROM_LAT cycles after rom_re
//  dmd_col     out  COL_W   DMD column index
//  dmd_data    out  DATA_W  DMD column data
//  dmd_load    out  1       1-cycle load strobe for dmd_col/dmd_data
//  dmd_clr     out  1       1-cycle DMD buffer clear
//  page        out  PAGE_W  current page (input page or view page) for 7-seg
//  wrap_done   out  1       1-cycle pulse when input wraps past the last address
// BEHAVIOUR
//  Reset: all outputs 0, col=0, in_page=0, view_page=0, FSM=IDLE, scan counters 0.
//  step/page_up/page_dn pass a 2-flop synchroniser and a rising-edge detector.
//  Edge pulse appears 3 CLK cycles after the raw rise.
//  Input mode (mode==0), one edge of step:
//   rom_we=1 with rom_addr={in_page,col} and rom_wdata=din.
//   dmd_load=1 in the same cycle with dmd_col=col and dmd_data=din.
//   col is incremented next cycle.
//   col==COLS-1: col->0, in_page++, dmd_clr pulses next cycle.
//   in_page==PAGES-1 and col==COLS-1: in_page->0 and wrap_done pulses together with dmd_clr.
//   page_up/page_dn are ignored in input mode.
//  View modes (mode 1/2): FSM IDLE -> READ -> WAIT -> LOAD -> IDLE.
//   IDLE: advance on a scan tick (every SCAN_DIV cycles).
//   READ: rom_re=1 for 1 cycle with rom_addr={view_page,col}.
//   WAIT: hold ROM_LAT-1 cycles.
//   LOAD: dmd_load=1, dmd_data=rom_rdata, dmd_col=col; col wraps modulo COLS.
//  page_up edge: view_page+1, wraps PAGES-1->0. page_dn edge: view_page-1, wraps 0->PAGES-1.
//  Any page change: col->0, dmd_clr pulse, FSM->IDLE; a READ already in flight is discarded.
//  page_up and page_dn edges in the same cycle: no change, no clr.
//  Mode change, detected as mode != mode_q: FSM->IDLE, col->0, dmd_clr pulse.
//   No rom_we/dmd_load is issued that cycle; a step edge in that cycle is dropped.
//  page = in_page in input mode, view_page otherwise; registered, 1-cycle latency.
//  RESET mid-scan or mid-write: outputs drop to 0 immediately (async).
// CONFIGURATION
//  ROM_PAGE_AUTO_PAGE_EN defined, view mode 1 only:
//   after AUTO_SCANS complete page scans (col wrap), view_page auto-increments as for page_up.
//   A manual page edge resets the scan count.
//  Macro undefined: no auto advance; the scan counter is not built.
// STRUCTURE
//  Package rom_page_pkg:
//   mode_t enum (MODE_INPUT=0, MODE_RUN=1, MODE_DEBUG=2).
//   scan_state_t enum (S_IDLE, S_READ, S_WAIT, S_LOAD).
//  Sub-module edge_sync (2-flop sync + rising-edge pulse), instantiated for step, page_up, page_dn.
// TESTING
//  Mode 0, din=16'hA5A5, one step edge:
//   rom_we with addr 0, data A5A5; dmd_load col 0; col becomes 1.
//  Mode 0, 32 steps from reset: addr 0..31 written, 32nd step -> in_page=1, dmd_clr pulse, page=1.
//  Mode 0, preload in_page=63 col=31, step: addr 2047 written, then in_page=0, wrap_done=1, dmd_clr=1.
//  Mode 2, page 0 preloaded with col value=col, SCAN_DIV=4, ROM_LAT=2:
//   dmd_load every scan slot with data 0,1,...,31,0.
//  Mode 2, page_dn at page 0: view_page=63, dmd_clr, next rom_re addr=63*32.
//   page_up and page_dn edges together: page unchanged, no dmd_clr.
//  Mode 1 with ROM_PAGE_AUTO_PAGE_EN, AUTO_SCANS=2: view_page increments after the 64th load.
//   Assert RESET mid-WAIT: all outputs 0 same cycle, page 0 after release.

Source files
------------

// File: rtl/rom_page_pkg.sv
// Package rom_page_pkg
//   Shared types for the ROM page scanner.
//   mode_t       : operating mode encoding on the 'mode' input
//                  (code 3 is reserved and behaves as MODE_RUN)
//   scan_state_t : view-mode scan FSM states
//   is_run_mode  : true for run mode and the reserved code
package rom_page_pkg;

  typedef enum logic [1:0] {
    MODE_INPUT = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_DEBUG = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } scan_state_t;

  function automatic logic is_run_mode(input logic [1:0] m);
    return (m == MODE_RUN) || (m == 2'd3);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Module edge_sync
//   Brings a raw asynchronous level into the CLK domain through two flops
//   and emits a registered one-cycle pulse on its rising edge. The pulse
//   appears 3 CLK cycles after the raw level rises.
// Ports
//   CLK   in  system clock
//   RESET in  asynchronous, active-high reset
//   raw   in  asynchronous level (button / switch)
//   pulse out one-cycle rising-edge pulse, registered
module edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/rom_page_scanner.sv
// Module rom_page_scanner
//   Paged ROM-image entry/viewer engine.
//   Input mode (mode 0): every step edge writes din to ROM at {in_page,col}
//   and mirrors it to the DMD column buffer; col/in_page advance and wrap.
//   View modes (mode 1/2, 3 = run): scans the selected view page from ROM
//   into the DMD one column per scan slot (IDLE->READ->WAIT->LOAD).
//   page_up/page_dn select the view page; the current page is exported.
// Configuration
//   ROM_PAGE_AUTO_PAGE_EN : when defined, run mode advances the view page
//   after AUTO_SCANS complete page scans. Undefined: no auto advance.
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   mode[1:0]           0=input, 1=run, 2=debug, 3=run
//   step/page_up/page_dn raw async levels, acted on at their rising edge
//   din[DATA_W]         switch word to commit
//   rom_addr/rom_we/rom_wdata/rom_re  ROM port; rom_rdata valid ROM_LAT
//                       cycles after rom_re
//   dmd_col/dmd_data/dmd_load/dmd_clr DMD column buffer port
//   page[PAGE_W]        current page for the 7-seg display
//   wrap_done           pulse when input wraps past the last address
//   dbg_state[1:0]      scan FSM state (scan_state_t encoding)
// Handshake: all strobes (rom_we, rom_re, dmd_load, dmd_clr, wrap_done) are
//   single-cycle registered pulses with their data valid in the same cycle;
//   there is no back-pressure.
module rom_page_scanner
  import rom_page_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int COLS       = 32,
  parameter  int PAGES      = 64,
  parameter  int SCAN_DIV   = 4,
  parameter  int ROM_LAT    = 1,
  parameter  int AUTO_SCANS = 8,
  localparam int COL_W      = $clog2(COLS),
  localparam int PAGE_W     = $clog2(PAGES),
  localparam int ADDR_W     = PAGE_W + COL_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              page_up,
  input  logic              page_dn,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              rom_re,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [COL_W-1:0]  dmd_col,
  output logic [DATA_W-1:0] dmd_data,
  output logic              dmd_load,
  output logic              dmd_clr,
  output logic [PAGE_W-1:0] page,
  output logic              wrap_done,
  output logic [1:0]        dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  // Last WAIT count before LOAD; WAIT is skipped entirely when ROM_LAT == 1.
  localparam logic [LAT_W-1:0]  WAIT_MAX = LAT_W'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);

  logic step_p, up_p, dn_p;

  edge_sync u_sync_step (.CLK(CLK), .RESET(RESET), .raw(step),    .pulse(step_p));
  edge_sync u_sync_up   (.CLK(CLK), .RESET(RESET), .raw(page_up), .pulse(up_p));
  edge_sync u_sync_dn   (.CLK(CLK), .RESET(RESET), .raw(page_dn), .pulse(dn_p));

  scan_state_t       state;
  logic [COL_W-1:0]  col;
  logic [PAGE_W-1:0] in_page;
  logic [PAGE_W-1:0] view_page;
  logic [1:0]        mode_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [LAT_W-1:0]  wait_cnt;
  // Input-mode page wrap: clear/wrap strobes follow the write by one cycle.
  logic              clr_pend;
  logic              wrap_pend;

  logic in_mode, mode_chg, tick, pg_up, pg_dn, view_chg, auto_adv;

  assign in_mode  = (mode == MODE_INPUT);
  assign mode_chg = (mode != mode_q);
  assign tick     = (div_cnt == DIV_MAX);
  // Simultaneous up and down cancel each other.
  assign pg_up    = up_p & ~dn_p;
  assign pg_dn    = dn_p & ~up_p;
  assign view_chg = ~in_mode & (pg_up | pg_dn);
  assign dbg_state = state;

`ifdef ROM_PAGE_AUTO_PAGE_EN
  localparam int SCAN_W = (AUTO_SCANS > 1) ? $clog2(AUTO_SCANS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(AUTO_SCANS - 1);

  logic [SCAN_W-1:0] scan_cnt;

  // Advance on the load that completes the AUTO_SCANS-th scan of the page.
  assign auto_adv = is_run_mode(mode) && !mode_chg && !view_chg &&
                    (state == S_LOAD) && (col == COL_MAX) && (scan_cnt == SCAN_MAX);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
    end else if (mode_chg || view_chg || !is_run_mode(mode)) begin
      scan_cnt <= '0;
    end else if ((state == S_LOAD) && (col == COL_MAX)) begin
      scan_cnt <= auto_adv ? '0 : scan_cnt + 1'b1;
    end
  end
`else
  logic unused_auto_cfg;
  assign unused_auto_cfg = (AUTO_SCANS > 0);
  assign auto_adv        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      col       <= '0;
      in_page   <= '0;
      view_page <= '0;
      mode_q    <= MODE_INPUT;
      div_cnt   <= '0;
      wait_cnt  <= '0;
      clr_pend  <= 1'b0;
      wrap_pend <= 1'b0;
      rom_addr  <= '0;
      rom_we    <= 1'b0;
      rom_wdata <= '0;
      rom_re    <= 1'b0;
      dmd_col   <= '0;
      dmd_data  <= '0;
      dmd_load  <= 1'b0;
      dmd_clr   <= 1'b0;
      page      <= '0;
      wrap_done <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      rom_re    <= 1'b0;
      dmd_load  <= 1'b0;
      dmd_clr   <= clr_pend;
      wrap_done <= wrap_pend;
      clr_pend  <= 1'b0;
      wrap_pend <= 1'b0;
      mode_q    <= mode;
      page      <= in_mode ? in_page : view_page;

      if (mode_chg) begin
        // Mode switch wins over everything, including a step edge this cycle.
        state    <= S_IDLE;
        col      <= '0;
        div_cnt  <= '0;
        wait_cnt <= '0;
        dmd_clr  <= 1'b1;
      end else if (in_mode) begin
        state    <= S_IDLE;
        div_cnt  <= '0;
        wait_cnt <= '0;
        if (step_p) begin
          rom_we    <= 1'b1;
          rom_addr  <= {in_page, col};
          rom_wdata <= din;
          dmd_load  <= 1'b1;
          dmd_col   <= col;
          dmd_data  <= din;
          col       <= col + 1'b1;
          if (col == COL_MAX) begin
            in_page  <= in_page + 1'b1;
            clr_pend <= 1'b1;
            if (in_page == PAGE_MAX) begin
              wrap_pend <= 1'b1;
            end
          end
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (view_chg) begin
          // Abandon any read in flight; its data is never loaded.
          view_page <= pg_dn ? view_page - 1'b1 : view_page + 1'b1;
          col       <= '0;
          state     <= S_IDLE;
          wait_cnt  <= '0;
          dmd_clr   <= 1'b1;
        end else begin
          case (state)
            S_IDLE: begin
              if (tick) begin
                state    <= S_READ;
                rom_re   <= 1'b1;
                rom_addr <= {view_page, col};
              end
            end
            S_READ: begin
              wait_cnt <= '0;
              state    <= (ROM_LAT > 1) ? S_WAIT : S_LOAD;
            end
            S_WAIT: begin
              if (wait_cnt == WAIT_MAX) begin
                state <= S_LOAD;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end
            S_LOAD: begin
              dmd_load <= 1'b1;
              dmd_data <= rom_rdata;
              dmd_col  <= col;
              col      <= col + 1'b1;
              state    <= S_IDLE;
              if (auto_adv) begin
                view_page <= view_page + 1'b1;
                dmd_clr   <= 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_page_scanner.sv
// Bench for rom_page_scanner: ROM model, write/load scoreboards, page and
// clear accounting, reset behaviour, optional auto page advance.
module tb_rom_page_scanner;

  localparam int DATA_W   = 16;
  localparam int COLS     = 32;
  localparam int PAGES    = 64;
  localparam int SCAN_DIV = 4;
  localparam int ROM_LAT  = 2;
  localparam int ADDR_W   = 11;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic [1:0]        mode;
  logic              step, page_up, page_dn;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_we, rom_re;
  logic [DATA_W-1:0] rom_wdata, rom_rdata;
  logic [4:0]        dmd_col;
  logic [DATA_W-1:0] dmd_data;
  logic              dmd_load, dmd_clr, wrap_done;
  logic [5:0]        page;
  logic [1:0]        dbg_state;

  rom_page_scanner #(
    .DATA_W(DATA_W), .COLS(COLS), .PAGES(PAGES),
    .SCAN_DIV(SCAN_DIV), .ROM_LAT(ROM_LAT), .AUTO_SCANS(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .mode(mode), .step(step),
    .page_up(page_up), .page_dn(page_dn), .din(din),
    .rom_addr(rom_addr), .rom_we(rom_we), .rom_wdata(rom_wdata),
    .rom_re(rom_re), .rom_rdata(rom_rdata),
    .dmd_col(dmd_col), .dmd_data(dmd_data), .dmd_load(dmd_load),
    .dmd_clr(dmd_clr), .page(page), .wrap_done(wrap_done),
    .dbg_state(dbg_state)
  );

  // ---------------- ROM model (ROM_LAT = 2) ----------------
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd1, rd2;
  always @(posedge CLK) begin
    if (rom_we) mem[rom_addr] <= rom_wdata;
    if (rom_re) rd1 <= mem[rom_addr];
    rd2 <= rd1;
  end
  assign rom_rdata = rd2;

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];   // expected {addr, data} writes
  logic [5+DATA_W-1:0]      ld_q[$];    // expected {col, data} loads
  int checks = 0;
  int errors = 0;
  int cyc = 0, ld_cnt = 0, clr_cnt = 0, wrap_cnt = 0;
  int ld_seen = 0, last_ld_cyc = 0;
  bit view_chk = 0, re_pending = 0, re_got = 0;
  logic [ADDR_W-1:0] re_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      cyc++;
      if (rom_we) begin
        if (exp_q.size() == 0) check("rom_we_unexpected", 1, 0);
        else check("rom_write", {rom_addr, rom_wdata}, exp_q.pop_front());
      end
      if (dmd_load) begin
        ld_cnt++;
        if (ld_q.size() > 0) begin
          check("dmd_load", {dmd_col, dmd_data}, ld_q.pop_front());
          if (view_chk) begin
            if (ld_seen > 0) check("load_gap", cyc - last_ld_cyc, SCAN_DIV);
            last_ld_cyc = cyc;
            ld_seen++;
          end
        end
      end
      if (rom_re && re_pending) begin
        re_addr    = rom_addr;
        re_pending = 0;
        re_got     = 1;
      end
      if (dmd_clr) begin
        clr_cnt++;
        re_pending = 1;
      end
      if (wrap_done) begin
        wrap_cnt++;
        check("wrap_with_clr", dmd_clr, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // which: 0 step, 1 page_up, 2 page_dn, 3 page_up+page_dn
  task automatic pulse_in(input int which);
    @(negedge CLK);
    step    = (which == 0);
    page_up = (which == 1) || (which == 3);
    page_dn = (which == 2) || (which == 3);
    repeat (4) @(negedge CLK);
    step = 0; page_up = 0; page_dn = 0;
    repeat (4) @(negedge CLK);
    #1;
  endtask

  task automatic do_step(input logic [DATA_W-1:0] d, input int pg, input int c);
    din = d;
    exp_q.push_back({6'(pg), 5'(c), d});
    ld_q.push_back({5'(c), d});
    pulse_in(0);
  endtask

  // ---------------- main sequence ----------------
  int base;
  int ep, ec;
  initial begin
    RESET = 1; mode = 2'd0; step = 0; page_up = 0; page_dn = 0; din = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_rom_we", rom_we, 0);
    check("rst_rom_re", rom_re, 0);
    check("rst_dmd_load", dmd_load, 0);
    check("rst_dmd_clr", dmd_clr, 0);
    check("rst_page", page, 0);
    check("rst_wrap", wrap_done, 0);
    @(negedge CLK);
    RESET = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("idle_page", page, 0);

    // Input mode: fill all 2048 addresses, first word A5A5.
    ep = 0; ec = 0;
    for (int i = 0; i < PAGES * COLS; i++) begin
      do_step((i == 0) ? 16'hA5A5 : 16'($urandom_range(0, 65535)), ep, ec);
      if (ec == COLS - 1) begin ec = 0; ep = (ep + 1) % PAGES; end
      else ec++;
      if (i == 0) begin
        check("first_no_clr", clr_cnt, 0);
        check("first_page", page, 0);
      end
      if (i == COLS - 1) begin
        check("page_after_32", page, 1);
        check("clr_after_32", clr_cnt, 1);
        check("no_wrap_yet", wrap_cnt, 0);
      end
    end
    check("wrap_count", wrap_cnt, 1);
    check("clr_count_full", clr_cnt, PAGES);
    check("page_after_wrap", page, 0);
    check("write_q_empty", exp_q.size(), 0);

    // Rewrite page 0 with data = col for the scan test.
    for (int c = 0; c < COLS; c++) do_step(16'(c), 0, c);
    check("page_after_rewrite", page, 1);
    check("clr_after_rewrite", clr_cnt, PAGES + 1);

    // Debug mode scan of page 0: 0..31 then 0.
    for (int c = 0; c < COLS; c++) ld_q.push_back({5'(c), 16'(c)});
    ld_q.push_back({5'd0, 16'd0});
    base = clr_cnt;
    view_chk = 1; ld_seen = 0;
    @(negedge CLK);
    mode = 2'd2;
    for (int t = 0; t < 400 && ld_q.size() > 0; t++) @(negedge CLK);
    #1;
    view_chk = 0;
    check("scan_loads_done", ld_q.size(), 0);
    check("scan_load_count", ld_seen, COLS + 1);
    check("clr_on_mode_change", clr_cnt - base, 1);
    check("view_page0", page, 0);

    // page_dn at page 0 wraps to 63.
    base = clr_cnt; re_got = 0; re_pending = 0;
    pulse_in(2);
    for (int t = 0; t < 30 && !re_got; t++) @(negedge CLK);
    #1;
    check("dn_page", page, 63);
    check("dn_clr", clr_cnt - base, 1);
    check("dn_re_seen", re_got, 1);
    check("dn_re_addr", re_addr, 63 * 32);

    // Both edges together: no change, no clear.
    base = clr_cnt;
    pulse_in(3);
    repeat (4) @(negedge CLK);
    #1;
    check("both_page", page, 63);
    check("both_no_clr", clr_cnt - base, 0);

    // page_up wraps 63 -> 0, then to 1.
    base = clr_cnt;
    pulse_in(1);
    check("up_wrap_page", page, 0);
    check("up_clr", clr_cnt - base, 1);
    pulse_in(1);
    check("up_page1", page, 1);

    // Reset while the scan FSM is in WAIT.
    re_got = 0;
    for (int t = 0; t < 30 && !rom_re; t++) @(negedge CLK);
    check("rom_re_before_reset", rom_re, 1);
    @(posedge CLK);
    #1;
    check("state_wait", dbg_state, 2);
    RESET = 1;
    #1;
    check("mid_rst_rom_re", rom_re, 0);
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_dmd_load", dmd_load, 0);
    check("mid_rst_dmd_data", dmd_data, 0);
    check("mid_rst_dmd_clr", dmd_clr, 0);
    check("mid_rst_page", page, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge CLK);
    RESET = 0;
    repeat (3) @(negedge CLK);
    #1;
    check("post_rst_page", page, 0);

`ifdef ROM_PAGE_AUTO_PAGE_EN
    // Run mode with AUTO_SCANS=2: advance after the 64th load.
    @(negedge CLK);
    mode = 2'd1;
    @(negedge CLK);
    ld_cnt = 0;
    for (int t = 0; t < 600 && page != 6'd1; t++) begin
      @(negedge CLK);
      #1;
    end
    check("auto_page", page, 1);
    check("auto_load_count", ld_cnt, 64);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
